// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC register, sequences the PC+4 incrementor,
// handshakes with instruction memory and applies stalls, redirects and IF/ID flushes.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PCAddResult,
  output logic [31:0] PCResult,
  output logic        WriteEn,
  output logic        IMemReq,
  input  logic        IMemAck,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        AlignErr,
  output logic [31:0] FetchCount
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  // A single-cycle flush window is fully covered by the redirect cycle itself.
  localparam logic SHORT_FLUSH = (FLUSH_CYCLES <= 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      pc_next;
  logic [31:0]      count_next;
  logic [31:0]      target;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] flush_cnt_next;
  logic             align_next;
  logic             redirect;

  // Redirect source selection; jump wins over a simultaneous branch.
  always_comb begin
    target   = Jump ? JumpTarget : BranchTarget;
    redirect = (Jump | BranchTaken) && (state != BOOT);
  end

  // Next-state, PC update and handshake outputs.
  always_comb begin
    state_next     = state;
    pc_next        = PCResult;
    count_next     = FetchCount;
    flush_cnt_next = flush_cnt;
    align_next     = 1'b0;
    WriteEn        = 1'b0;
    IFIDWrite      = 1'b0;
    IMemReq        = 1'b0;
    IFIDFlush      = 1'b0;

    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        IMemReq = 1'b1;
        if (Stall) begin
          state_next = STALL;
        end else if (IMemAck) begin
          WriteEn    = 1'b1;
          IFIDWrite  = 1'b1;
          pc_next    = PCAddResult;
          count_next = FetchCount + 32'd1;
        end
      end
      STALL: begin
        if (!Stall) begin
          state_next = FETCH;
        end
      end
      FLUSH: begin
        IFIDFlush = 1'b1;
        if (flush_cnt <= CNT_W'(1)) begin
          flush_cnt_next = '0;
          state_next     = FETCH;
        end else begin
          flush_cnt_next = flush_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase

    // Redirect overrides stall and ack handling; any ack this cycle is dropped.
    if (redirect) begin
      WriteEn        = 1'b0;
      IFIDWrite      = 1'b0;
      count_next     = FetchCount;
      IFIDFlush      = 1'b1;
      pc_next        = {target[31:2], 2'b00};
      align_next     = |target[1:0];
      flush_cnt_next = FLUSH_INIT;
      state_next     = SHORT_FLUSH ? FETCH : FLUSH;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= BOOT;
      PCResult   <= RESET_PC;
      FetchCount <= '0;
      flush_cnt  <= '0;
      AlignErr   <= 1'b0;
    end else begin
      state      <= state_next;
      PCResult   <= pc_next;
      FetchCount <= count_next;
      flush_cnt  <= flush_cnt_next;
      AlignErr   <= align_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed table-driven bench for pc_fetch_sequencer with FLUSH_CYCLES=2 and a
// behavioural PC+4 incrementor closing the loop.
module tb_pc_fetch_sequencer;

  logic        Clk;
  logic        Rst;
  logic [31:0] PCAddResult;
  logic [31:0] PCResult;
  logic        WriteEn;
  logic        IMemReq;
  logic        IMemAck;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        AlignErr;
  logic [31:0] FetchCount;

  int tests;
  int failed;

  pc_fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .PCAddResult (PCAddResult),
    .PCResult    (PCResult),
    .WriteEn     (WriteEn),
    .IMemReq     (IMemReq),
    .IMemAck     (IMemAck),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .IFIDWrite   (IFIDWrite),
    .IFIDFlush   (IFIDFlush),
    .AlignErr    (AlignErr),
    .FetchCount  (FetchCount)
  );

  // Incrementor: returns PC+4 when enabled, otherwise the PC itself.
  assign PCAddResult = WriteEn ? (PCResult + 32'd4) : PCResult;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        stall;
    logic        ack;
    logic        jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic [31:0] pc;
    logic        we;
    logic        req;
    logic        ifw;
    logic        fl;
    logic        ae;
    logic [31:0] fc;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] pc, input logic we,
                         input logic req, input logic ifw, input logic fl,
                         input logic ae, input logic [31:0] fc);
    chk("PCResult", idx, PCResult, pc);
    chk("WriteEn", idx, 32'(WriteEn), 32'(we));
    chk("IMemReq", idx, 32'(IMemReq), 32'(req));
    chk("IFIDWrite", idx, 32'(IFIDWrite), 32'(ifw));
    chk("IFIDFlush", idx, 32'(IFIDFlush), 32'(fl));
    chk("AlignErr", idx, 32'(AlignErr), 32'(ae));
    chk("FetchCount", idx, FetchCount, fc);
  endtask

  task automatic drive(input logic stall, input logic ack, input logic jump,
                       input logic [31:0] jt, input logic br, input logic [31:0] bt);
    Stall        = stall;
    IMemAck      = ack;
    Jump         = jump;
    JumpTarget   = jt;
    BranchTaken  = br;
    BranchTarget = bt;
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    //          stall ack  jump jt            br   bt            | pc            we   req  ifw  fl   ae   fc
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0004, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0008, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_000C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_000C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_000C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0014, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h400,      1'b1, 32'h200, 32'h0000_0014, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0400, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0404, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h123, 32'h0000_0404, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0120, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd6};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0120, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 32'h401,      1'b0, 32'h0,   32'h0000_0120, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd6};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,  32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd6};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7};

    // Hold reset with activity on the inputs; outputs must stay quiet.
    Rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    #1 Rst = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #1 chk_all(-1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Release reset away from the rising edge, then play the vector table.
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].stall, vecs[i].ack, vecs[i].jump, vecs[i].jt, vecs[i].br, vecs[i].bt);
      #1 chk_all(i, vecs[i].pc, vecs[i].we, vecs[i].req, vecs[i].ifw, vecs[i].fl,
                 vecs[i].ae, vecs[i].fc);
      @(negedge Clk);
    end

    // Asynchronous reset while in FLUSH at PC 0x400.
    drive(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    #1 chk_all(100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd7);
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1 chk_all(101, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7);
    #2 Rst = 1'b0;
    #1 chk_all(102, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Restart: one BOOT cycle, then fetch from RESET_PC.
    @(negedge Clk);
    Rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1 chk_all(103, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge Clk);
    #1 chk_all(104, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge Clk);
    #1 chk_all(105, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch-stage controller that owns the program counter register. It sequences the PC+4 incrementor by driving its PCResult input and WriteEn, and accepting its PCAddResult. It handshakes with instruction memory, applies hazard stalls, and performs branch/jump redirects with an IF/ID flush window. It sits between the hazard/branch logic in ID and the PC incrementor, instruction memory and IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 1, number of cycles IF/ID flush is held after a redirect (1..7).

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous, active-low reset.
PCAddResult  input  32  incremented PC returned from the incrementor.
PCResult  output  32  current PC; drives the incrementor and instruction memory address.
WriteEn  output  1  incrementor enable and PC advance strobe.
IMemReq  output  1  fetch request to instruction memory.
IMemAck  input  1  instruction memory data valid for the current PCResult.
Stall  input  1  load-use hazard; holds the fetch.
BranchTaken  input  1  taken branch resolved in ID.
BranchTarget  input  32  branch destination.
Jump  input  1  jump resolved in ID.
JumpTarget  input  32  jump destination.
IFIDWrite  output  1  IF/ID register load enable.
IFIDFlush  output  1  IF/ID register clear.
AlignErr  output  1  one-cycle pulse when a redirect target has nonzero bits [1:0].
FetchCount  output  32  number of accepted fetches since reset.

Behaviour:
- The single clock is Clk. Reset is asynchronous and active-low on Rst.
- Reset values (Rst=0): PCResult=RESET_PC, state=BOOT, FetchCount=0, flush counter=0, AlignErr=0. While in reset, WriteEn, IMemReq, IFIDWrite and IFIDFlush are all 0.
- Reset asserted mid-operation aborts immediately: any outstanding request is dropped and no PC update occurs.
- States:
  - BOOT: lasts 1 cycle, then FETCH.
  - FETCH: IMemReq=1.
  - STALL: IMemReq=0.
  - FLUSH: IMemReq=0, IFIDFlush=1.
- redirect = (Jump | BranchTaken) and state in {FETCH, STALL, FLUSH}.
- Target selection: Jump has priority over BranchTaken. The PC is loaded with {target[31:2], 2'b00}. AlignErr is registered and equals 1 in the cycle after a redirect whose target[1:0] != 0.
- Priority in a cycle: redirect > Stall > IMemAck.
  - On redirect: PCResult <= target, IFIDFlush=1 in the same cycle (combinational), flush counter <= FLUSH_CYCLES-1, next state = FLUSH (FETCH if FLUSH_CYCLES=1 and counter reaches 0). WriteEn=0. An IMemAck in that cycle is discarded.
  - FETCH with Stall (no redirect): IMemAck is ignored, and the instruction is refetched later (instruction memory is read-only, so refetch is safe). Next state = STALL. WriteEn=IFIDWrite=0.
  - FETCH with IMemAck & !Stall & !redirect: WriteEn=1 and IFIDWrite=1 (both combinational). PCResult <= PCAddResult. FetchCount += 1, wrapping modulo 2^32. State remains FETCH.
  - FETCH with no ack: hold PCResult. IMemReq stays 1. There is no timeout.
  - STALL: the state remains STALL while Stall=1. When Stall=0, next state = FETCH with PCResult unchanged.
  - FLUSH: IFIDFlush=1 and the flush counter decrements each cycle. At 0, next state = FETCH. A redirect during FLUSH reloads the PC and restarts the counter. Stall is ignored in FLUSH.
- When WriteEn=0, PCAddResult equals PCResult by the incrementor contract, so the PC never advances unintentionally.
- The PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no error.

Test Plan:
- Reset then run: Rst low→high, IMemAck=1 constantly, no hazards → BOOT 1 cycle, then PCResult 0,4,8,C on successive cycles; FetchCount=3 after three accepts.
- Slow memory: IMemAck high every 3rd FETCH cycle → PCResult holds 2 cycles, WriteEn pulses only on ack cycles, IMemReq continuously 1.
- Stall with simultaneous ack at PC=0x10: Stall=1 for 2 cycles → ack discarded, IMemReq=0 in STALL, PC=0x10 refetched, and FetchCount advances only once for 0x10.
- Jump and branch same cycle: Jump=1 to 0x400, BranchTaken=1 to 0x200, FLUSH_CYCLES=2 → PCResult=0x400, IFIDFlush high for 2 cycles, FETCH resumes at 0x400; no AlignErr.
- Misaligned branch to 0x123 during STALL → PCResult=0x120, AlignErr pulses 1 cycle, state goes FLUSH then FETCH.
- Async reset in FLUSH at PC=0x400 → PCResult=RESET_PC immediately without a clock edge, IFIDFlush=0, and the sequence restarts from BOOT.
